// File: rtl/alloc_pkg.sv
// Shared types for the entry allocation controller: default pool size and
// the index/count widths derived from it.
package alloc_pkg;
    localparam int LOG_ENTRIES = 3;
    typedef logic [LOG_ENTRIES-1:0] entry_idx_t;
    typedef logic [LOG_ENTRIES:0]   entry_cnt_t;
endpackage

// File: rtl/lowest_free_encoder.sv
// Combinational search over the busy bitmap: index of the lowest clear bit,
// with any_free low (and idx 0) when every entry is busy.
module lowest_free_encoder #(
    parameter int LOG_ENTRIES = alloc_pkg::LOG_ENTRIES
) (
    input  logic [(2**LOG_ENTRIES)-1:0] busy,
    output logic [LOG_ENTRIES-1:0]      idx,
    output logic                        any_free
);
    import alloc_pkg::*;

    localparam int N = 2**LOG_ENTRIES;

    // Scanning downward lets the lowest free index win the last assignment.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx      = LOG_ENTRIES'(i);
                any_free = 1'b1;
            end
        end
    end
endmodule

// File: rtl/entry_alloc_ctrl.sv
// Allocation controller: keeps a busy bitmap, offers the lowest free entry on
// a registered valid/ready port, accepts one release per cycle, supports flush.
module entry_alloc_ctrl #(
    parameter int LOG_ENTRIES = alloc_pkg::LOG_ENTRIES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   alloc_valid,
    input  logic                   alloc_ready,
    output logic [LOG_ENTRIES-1:0] alloc_idx,
    input  logic                   free_valid,
    input  logic [LOG_ENTRIES-1:0] free_idx,
    input  logic                   flush,
    output logic [LOG_ENTRIES:0]   used_count,
    output logic                   full,
    output logic                   err_bad_free
);
    import alloc_pkg::*;

    localparam int N = 2**LOG_ENTRIES;

    logic [N-1:0]           busy, busy_nxt;
    logic                   valid_nxt, err_nxt;
    logic [LOG_ENTRIES-1:0] idx_nxt, enc_idx;
    logic [LOG_ENTRIES:0]   cnt_nxt;
    logic                   enc_any, grant, can_load, free_ok;

    lowest_free_encoder #(.LOG_ENTRIES(LOG_ENTRIES)) u_enc (
        .busy     (busy),
        .idx      (enc_idx),
        .any_free (enc_any)
    );

    assign grant    = alloc_valid && alloc_ready;
    assign can_load = !alloc_valid || grant;
    // The reserved entry is busy but not yet owned by anyone, so it cannot be freed.
    assign free_ok  = free_valid && busy[free_idx] &&
                      !(alloc_valid && (free_idx == alloc_idx));
    assign full     = (used_count == (LOG_ENTRIES+1)'(N));

    always_comb begin
        busy_nxt  = busy;
        valid_nxt = alloc_valid;
        idx_nxt   = alloc_idx;
        cnt_nxt   = used_count;
        err_nxt   = err_bad_free;
        if (flush) begin
            busy_nxt  = '0;
            valid_nxt = 1'b0;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            if (free_valid && !free_ok)
                err_nxt = 1'b1;
            if (free_ok)
                busy_nxt[free_idx] = 1'b0;
            // Load decision uses the pre-edge bitmap, so it never picks the entry being freed.
            if (can_load) begin
                valid_nxt = enc_any;
                if (enc_any) begin
                    idx_nxt           = enc_idx;
                    busy_nxt[enc_idx] = 1'b1;
                end
            end
            if (grant && !free_ok)
                cnt_nxt = used_count + (LOG_ENTRIES+1)'(1);
            else if (!grant && free_ok)
                cnt_nxt = used_count - (LOG_ENTRIES+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            alloc_valid  <= 1'b0;
            alloc_idx    <= '0;
            used_count   <= '0;
            err_bad_free <= 1'b0;
        end else begin
            busy         <= busy_nxt;
            alloc_valid  <= valid_nxt;
            alloc_idx    <= idx_nxt;
            used_count   <= cnt_nxt;
            err_bad_free <= err_nxt;
        end
    end
endmodule

// File: tb/tb_entry_alloc_ctrl.sv
// Directed, table-driven bench for entry_alloc_ctrl with a 4-entry pool,
// plus hand-written reset sequences.
module tb_entry_alloc_ctrl;
    localparam int LE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [LE-1:0] alloc_idx;
    logic          free_valid;
    logic [LE-1:0] free_idx;
    logic          flush;
    logic [LE:0]   used_count;
    logic          full;
    logic          err_bad_free;

    int n_checks = 0;
    int n_fail   = 0;

    entry_alloc_ctrl #(.LOG_ENTRIES(LE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .flush        (flush),
        .used_count   (used_count),
        .full         (full),
        .err_bad_free (err_bad_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          fv;
        logic [LE-1:0] fi;
        logic          rdy;
        logic          ev;
        logic [LE-1:0] ei;
        logic [LE:0]   ec;
        logic          ef;
        logic          ee;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];
    int   nfill = 0;

    task automatic add(input logic fl, input logic fv, input int fi, input logic rdy,
                       input logic ev, input int ei, input int ec, input logic ef,
                       input logic ee);
        vecs[nfill].fl  = fl;
        vecs[nfill].fv  = fv;
        vecs[nfill].fi  = LE'(fi);
        vecs[nfill].rdy = rdy;
        vecs[nfill].ev  = ev;
        vecs[nfill].ei  = LE'(ei);
        vecs[nfill].ec  = (LE+1)'(ec);
        vecs[nfill].ef  = ef;
        vecs[nfill].ee  = ee;
        nfill++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input int ei,
                                 input int ec, input logic ef, input logic ee);
        check({tag, " alloc_valid"}, int'(alloc_valid), int'(ev));
        if (ev)
            check({tag, " alloc_idx"}, int'(alloc_idx), ei);
        check({tag, " used_count"}, int'(used_count), ec);
        check({tag, " full"}, int'(full), int'(ef));
        check({tag, " err_bad_free"}, int'(err_bad_free), int'(ee));
    endtask

    initial begin
        //   fl fv fi rdy  ev ei ec ef ee
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);  // reset release: index 0 offered
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0, 0, 1,   1, 1, 1, 0, 0);  // grants 0,1,2,3 back to back
        add(0, 0, 0, 1,   1, 2, 2, 0, 0);
        add(0, 0, 0, 1,   1, 3, 3, 0, 0);
        add(0, 0, 0, 1,   0, 0, 4, 1, 0);  // 4th grant: full, nothing left
        add(0, 0, 0, 0,   0, 0, 4, 1, 0);
        add(0, 1, 2, 0,   0, 0, 3, 0, 0);  // free 2: count drops, not yet offered
        add(0, 0, 0, 0,   1, 2, 3, 0, 0);  // entry 2 offered two cycles after its free
        add(0, 0, 0, 1,   0, 0, 4, 1, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0, 0);  // flush
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0, 0, 1,   1, 1, 1, 0, 0);
        add(0, 0, 0, 1,   1, 2, 2, 0, 0);  // {0,1} granted, 2 reserved
        add(0, 1, 0, 1,   1, 3, 2, 0, 0);  // grant 2 + free 0: next offer is 3
        add(0, 0, 0, 1,   1, 0, 3, 0, 0);  // grant 3: now 0 is offered
        add(0, 0, 0, 0,   1, 0, 3, 0, 0);
        add(0, 1, 3, 0,   1, 0, 2, 0, 0);  // legal free of 3
        add(0, 1, 3, 0,   1, 0, 2, 0, 1);  // 3 already free: error, nothing changes
        add(0, 1, 0, 0,   1, 0, 2, 0, 1);  // reserved entry freed: error, nothing changes
        add(0, 0, 0, 1,   1, 3, 3, 0, 1);  // bitmap intact: after granting 0, 3 offered
        add(1, 1, 1, 1,   0, 0, 0, 0, 1);  // flush beats grant and free; error retained
        add(0, 0, 0, 0,   1, 0, 0, 0, 1);
        add(0, 0, 0, 1,   1, 1, 1, 0, 1);

        rst_n       = 1'b0;
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        free_idx    = '0;
        flush       = 1'b0;
        #1;
        check_outputs("reset", 1'b0, 0, 0, 1'b0, 1'b0);
        check("reset alloc_idx", int'(alloc_idx), 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < nfill; k++) begin
            flush       = vecs[k].fl;
            free_valid  = vecs[k].fv;
            free_idx    = vecs[k].fi;
            alloc_ready = vecs[k].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", k), vecs[k].ev, int'(vecs[k].ei),
                          int'(vecs[k].ec), vecs[k].ef, vecs[k].ee);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a low clock phase.
        flush       = 1'b0;
        free_valid  = 1'b0;
        alloc_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 0, 0, 1'b0, 1'b0);
        check("async_rst alloc_idx", int'(alloc_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 1'b1, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        alloc_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst_grant", 1'b1, 1, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
